// File: rtl/async_input_debounce_if.sv
// Signal bundle between the debounce filter and its consumers.
// The debouncer attaches through the master modport; the logic that feeds
// sync_in and consumes the clean level/strobes attaches through slave.
// Optional event-counter signals exist only when DEB_EVENT_COUNT_EN is defined.
interface async_input_debounce_if #(
  parameter int CNT_W = 8
);
  logic             sync_in;
  logic             clean_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic             busy;
`ifdef DEB_EVENT_COUNT_EN
  logic             evt_clr;
  logic [CNT_W-1:0] evt_count;
  logic             evt_ovf;

  modport master (
    input  sync_in, evt_clr,
    output clean_out, rise_pulse, fall_pulse, busy, evt_count, evt_ovf
  );

  modport slave (
    output sync_in, evt_clr,
    input  clean_out, rise_pulse, fall_pulse, busy, evt_count, evt_ovf
  );
`else
  modport master (
    input  sync_in,
    output clean_out, rise_pulse, fall_pulse, busy
  );

  modport slave (
    output sync_in,
    input  clean_out, rise_pulse, fall_pulse, busy
  );
`endif
endinterface

// File: rtl/async_input_debounce.sv
// Glitch filter and edge detector for one already-synchronized input.
// A new level is accepted only after FILTER_CYCLES consecutive samples that
// differ from the current clean level; acceptance produces a one-cycle
// rise or fall strobe in the same cycle clean_out changes. All outputs are
// registered.
// Optional feature (macro DEB_EVENT_COUNT_EN): saturating counter of accepted
// rising edges with a sticky overflow flag and a synchronous clear.
module async_input_debounce #(
  parameter int FILTER_CYCLES = 16,
  parameter bit RESET_LEVEL   = 1'b0,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  async_input_debounce_if.master deb
);

  localparam int QW = $clog2(FILTER_CYCLES + 1);
  // Counter value at which the next differing sample completes qualification.
  localparam logic [QW-1:0] LAST_CNT = QW'(FILTER_CYCLES - 1);

  typedef enum logic {
    ST_STABLE,
    ST_CHECK
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          busy_q, busy_d;
  logic          differ;
  logic          toggle;

  // State, qualification counter and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      clean_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: qualify a run of samples that differ from clean level.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    busy_d  = busy_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    toggle  = 1'b0;
    differ  = (deb.sync_in != clean_q);

    unique case (state_q)
      ST_STABLE: begin
        if (differ) begin
          if (FILTER_CYCLES == 1) begin
            // A single differing sample is already a full run.
            toggle = 1'b1;
          end else begin
            state_d = ST_CHECK;
            cnt_d   = QW'(1);
            busy_d  = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (!differ) begin
          // Glitch: the input returned to the accepted level early.
          state_d = ST_STABLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          toggle  = 1'b1;
          state_d = ST_STABLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (toggle) begin
      clean_d = ~clean_q;
      rise_d  = ~clean_q;
      fall_d  = clean_q;
    end
  end

  assign deb.clean_out  = clean_q;
  assign deb.rise_pulse = rise_q;
  assign deb.fall_pulse = fall_q;
  assign deb.busy       = busy_q;

`ifdef DEB_EVENT_COUNT_EN
  localparam logic [CNT_W-1:0] EVT_MAX = '1;

  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             evt_ovf_q, evt_ovf_d;

  // Event counter next state; counts on rise_d so the count moves in the
  // same cycle rise_pulse is seen. A clear coinciding with a rise keeps
  // that rise.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    evt_ovf_d = evt_ovf_q;
    if (rise_d) begin
      if (deb.evt_clr) begin
        evt_cnt_d = CNT_W'(1);
        evt_ovf_d = 1'b0;
      end else if (evt_cnt_q == EVT_MAX) begin
        evt_ovf_d = 1'b1;
      end else begin
        evt_cnt_d = evt_cnt_q + 1'b1;
      end
    end else if (deb.evt_clr) begin
      evt_cnt_d = '0;
      evt_ovf_d = 1'b0;
    end
  end

  // Event counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt_q <= '0;
      evt_ovf_q <= 1'b0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
      evt_ovf_q <= evt_ovf_d;
    end
  end

  assign deb.evt_count = evt_cnt_q;
  assign deb.evt_ovf   = evt_ovf_q;
`endif

endmodule

// File: tb/tb_async_input_debounce.sv
// Bench for async_input_debounce with FILTER_CYCLES=4, RESET_LEVEL=0, CNT_W=2.
// A run-length model predicts every output each cycle; directed sequences
// add literal expectations at the interesting edges.
module tb_async_input_debounce;

  localparam int F     = 4;
  localparam int CNT_W = 2;
  localparam int EVMAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  async_input_debounce_if #(.CNT_W(CNT_W)) deb_if ();

  async_input_debounce #(
    .FILTER_CYCLES(F),
    .RESET_LEVEL  (1'b0),
    .CNT_W        (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .deb(deb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accepted level plus length of the current run of samples that
  // differ from it; a run of F samples flips the level.
  bit m_level;
  int m_run;
  bit m_rise;
  bit m_fall;
  int m_evt;
  bit m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = 1'b0;
      m_run   = 0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_evt   = 0;
      m_ovf   = 1'b0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (deb_if.sync_in != m_level) begin
        m_run = m_run + 1;
        if (m_run == F) begin
          m_level = !m_level;
          m_run   = 0;
          m_rise  = m_level;
          m_fall  = !m_level;
        end
      end else begin
        m_run = 0;
      end
`ifdef DEB_EVENT_COUNT_EN
      if (m_rise) begin
        if (deb_if.evt_clr) begin
          m_evt = 1;
          m_ovf = 1'b0;
        end else if (m_evt == EVMAX) begin
          m_ovf = 1'b1;
        end else begin
          m_evt = m_evt + 1;
        end
      end else if (deb_if.evt_clr) begin
        m_evt = 0;
        m_ovf = 1'b0;
      end
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_clean", 32'(deb_if.clean_out), 32'(m_level));
    check("m_rise", 32'(deb_if.rise_pulse), 32'(m_rise));
    check("m_fall", 32'(deb_if.fall_pulse), 32'(m_fall));
    check("m_busy", 32'(deb_if.busy), 32'(m_run > 0));
    check("m_excl", 32'(deb_if.rise_pulse & deb_if.fall_pulse), 32'd0);
`ifdef DEB_EVENT_COUNT_EN
    check("m_evt", 32'(deb_if.evt_count), 32'(m_evt));
    check("m_ovf", 32'(deb_if.evt_ovf), 32'(m_ovf));
`endif
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input bit c, input bit r, input bit f, input bit b);
    check({tag, "_clean"}, 32'(deb_if.clean_out), 32'(c));
    check({tag, "_rise"}, 32'(deb_if.rise_pulse), 32'(r));
    check({tag, "_fall"}, 32'(deb_if.fall_pulse), 32'(f));
    check({tag, "_busy"}, 32'(deb_if.busy), 32'(b));
  endtask

  initial begin
    rst            = 1'b1;
    deb_if.sync_in = 1'b0;
`ifdef DEB_EVENT_COUNT_EN
    deb_if.evt_clr = 1'b0;
`endif

    // 1: reset held with the input toggling.
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DEB_EVENT_COUNT_EN
      check("rst_hold_evt", 32'(deb_if.evt_count), 32'd0);
`endif
      deb_if.sync_in = ~deb_if.sync_in;
    end
    deb_if.sync_in = 1'b0;
    rst = 1'b0;
    tick();

    // 2: clean rise after F samples, strobe for one cycle.
    deb_if.sync_in = 1'b1;
    for (int i = 0; i < F - 1; i++) begin
      tick();
      expect_out("rise_qual", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    expect_out("rise_acc", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("rise_after", 1'b1, 1'b0, 1'b0, 1'b0);

    // 4: fall from clean_out=1.
    deb_if.sync_in = 1'b0;
    for (int i = 0; i < F - 1; i++) begin
      tick();
      expect_out("fall_qual", 1'b1, 1'b0, 1'b0, 1'b1);
    end
    tick();
    expect_out("fall_acc", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("fall_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: glitch of F-1 samples is rejected.
    deb_if.sync_in = 1'b1;
    for (int i = 0; i < F - 1; i++) begin
      tick();
      expect_out("glitch_qual", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    deb_if.sync_in = 1'b0;
    tick();
    expect_out("glitch_rej", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("glitch_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset in the middle of qualification discards the count.
    deb_if.sync_in = 1'b1;
    tick();
    tick();
    expect_out("mid_qual", 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 expect_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < F - 1; i++) begin
      tick();
      expect_out("post_rst_qual", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    expect_out("post_rst_acc", 1'b1, 1'b1, 1'b0, 1'b0);
    deb_if.sync_in = 1'b0;
    repeat (F + 2) tick();
    expect_out("post_rst_low", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef DEB_EVENT_COUNT_EN
    // 5: counter saturation, sticky overflow, clear coinciding with a rise.
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      deb_if.sync_in = 1'b1;
      repeat (F + 1) tick();
      deb_if.sync_in = 1'b0;
      repeat (F + 1) tick();
    end
    check("sat_evt", 32'(deb_if.evt_count), 32'd3);
    check("sat_ovf", 32'(deb_if.evt_ovf), 32'd1);
    deb_if.sync_in = 1'b1;
    repeat (F - 1) tick();
    deb_if.evt_clr = 1'b1;
    tick();
    deb_if.evt_clr = 1'b0;
    check("clr_rise", 32'(deb_if.rise_pulse), 32'd1);
    check("clr_evt", 32'(deb_if.evt_count), 32'd1);
    check("clr_ovf", 32'(deb_if.evt_ovf), 32'd0);
    tick();
    check("clr_hold_evt", 32'(deb_if.evt_count), 32'd1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
